// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encodings and default pattern for the serial pattern source
package seq_pkg;

  // Sequencer states, 2-bit encoding shared with detector benches
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  // Default pattern recognised by the 1101 Moore detector
  localparam logic [3:0] DEF_PAT_1101 = 4'b1101;

endpackage

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - W-bit loadable left-shift register with MSB tap
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;

  // Clear beats load beats shift; zeros fill from the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (clr) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_gen_moore.sv
// rtl/seq_gen_moore.sv - Moore serial pattern transmitter with repeat count and idle gap
module seq_gen_moore
  import seq_pkg::*;
#(
  parameter int             W       = 4,
  parameter logic [W-1:0]   DEF_PAT = W'(DEF_PAT_1101),
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pat_sel,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [3:0]       gap,
  output logic             output_bit,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  seq_state_e       state_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic [3:0]       gap_q;
  logic [CNT_W-1:0] reps_rem_q;
  logic [W-1:0]     pat_q;

  logic [W-1:0]     sel_pat;
  logic             last_bit;
  logic             more_reps;
  logic             sr_clr;
  logic             sr_load;
  logic             sr_shift;
  logic [W-1:0]     sr_din;
  logic             sr_msb;

  assign sel_pat   = pat_sel ? pattern : DEF_PAT;
  assign last_bit  = (state_q == S_SEND) && (bit_cnt_q == LAST_BIT);
  assign more_reps = (reps_rem_q > CNT_W'(1));

  // Shift-register control mirrors the FSM transitions: load on accepted start or reload, shift mid-copy
  always_comb begin
    sr_clr   = abort;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = (state_q == S_IDLE) ? sel_pat : pat_q;
    if (!abort) begin
      case (state_q)
        S_IDLE:  sr_load  = start && (reps != '0);
        S_SEND:  begin
          sr_load  = last_bit && more_reps && (gap_q == 4'd0);
          sr_shift = !last_bit;
        end
        S_GAP:   sr_load  = (gap_cnt_q == 4'd1);
        default: sr_load  = 1'b0;
      endcase
    end
  end

  // Sequencer: state, bit/gap/repeat counters and latched run parameters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      gap_q      <= '0;
      reps_rem_q <= '0;
      pat_q      <= '0;
    end else if (abort) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      reps_rem_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_q      <= sel_pat;
            gap_q      <= gap;
            reps_rem_q <= reps;
            bit_cnt_q  <= '0;
            state_q    <= (reps == '0) ? S_DONE : S_SEND;
          end
        end
        S_SEND: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q  <= '0;
            // Remaining count is at least 1 here, so this never wraps
            reps_rem_q <= reps_rem_q - CNT_W'(1);
            if (!more_reps) begin
              state_q <= S_DONE;
            end else if (gap_q != 4'd0) begin
              gap_cnt_q <= gap_q;
              state_q   <= S_GAP;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        S_GAP: begin
          gap_cnt_q <= gap_cnt_q - 4'd1;
          if (gap_cnt_q == 4'd1) begin
            state_q <= S_SEND;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  seq_shift_reg #(.W(W)) u_shift (
    .clk   (clk),
    .rst_n (rst),
    .clr   (sr_clr),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  // Moore outputs: decoded only from registered state and shift-register MSB
  assign output_bit = (state_q == S_SEND) && sr_msb;
  assign bit_valid  = (state_q == S_SEND);
  assign busy       = (state_q == S_SEND) || (state_q == S_GAP);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_gen_moore.sv
// tb/tb_seq_gen_moore.sv - scoreboard bench for seq_gen_moore
module tb_seq_gen_moore;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       pat_sel;
  logic [3:0] pattern;
  logic [7:0] reps;
  logic [3:0] gap;
  logic       output_bit;
  logic       bit_valid;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_fail;
  int busy_cnt;
  int gap_seen;
  int exp_q[$];

  seq_gen_moore dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pat_sel    (pat_sel),
    .pattern    (pattern),
    .reps       (reps),
    .gap        (gap),
    .output_bit (output_bit),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entry 0/1 is an expected serial bit, 2 is an expected done pulse
  task automatic push_copies(input logic [3:0] pat, input int n);
    for (int r = 0; r < n; r++)
      for (int i = 3; i >= 0; i--)
        exp_q.push_back(int'(pat[i]));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bit or a done pulse
  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_cnt++;
      if (bit_valid) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("serial_bit", int'(output_bit), exp_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_pulse", 2 + int'(busy), exp_q.pop_front());
      end
      if (busy && !bit_valid) begin
        gap_seen++;
        chk("gap_bit_zero", int'(output_bit), 0);
      end
    end
  end

  // Accept a run at the next edge; returns in cycle 1 of the run
  task automatic kick(input logic sel, input logic [3:0] pat, input int r, input int g);
    @(posedge clk); #1;
    pat_sel  = sel;
    pattern  = pat;
    reps     = 8'(r);
    gap      = 4'(g);
    start    = 1'b1;
    busy_cnt = 0;
    gap_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; cur is the run cycle index at entry
  task automatic finish(input string name, input int cur, input int exp_cyc, input int exp_busy, input int exp_gap);
    int c;
    bit found;
    c = cur;
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
      c++;
      @(posedge clk); #1;
    end
    if (!found) chk({name, "_timeout"}, 0, 1);
    chk({name, "_done_cycle"}, c, exp_cyc);
    chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({name, "_gap_cycles"}, gap_seen, exp_gap);
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; busy_cnt = 0; gap_seen = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; pat_sel = 1'b0;
    pattern = 4'b0000; reps = 8'd0; gap = 4'd0;
    #1;
    chk("rst_output_bit", int'(output_bit), 0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single default copy
    push_copies(4'b1101, 1); exp_q.push_back(2);
    kick(1'b0, 4'b0000, 1, 0);
    finish("t1", 1, 5, 4, 0);

    // Three back-to-back copies, no bubbles
    push_copies(4'b1101, 3); exp_q.push_back(2);
    kick(1'b0, 4'b0000, 3, 0);
    finish("t2", 1, 13, 12, 0);

    // Two copies with a two-cycle gap
    push_copies(4'b1101, 2); exp_q.push_back(2);
    kick(1'b0, 4'b0000, 2, 2);
    finish("t3", 1, 11, 10, 2);

    // Custom pattern, zero repeats: done only
    exp_q.push_back(2);
    kick(1'b1, 4'b1010, 0, 0);
    finish("t4", 1, 1, 0, 0);

    // Custom pattern, two copies, one-cycle gap
    push_copies(4'b1010, 2); exp_q.push_back(2);
    kick(1'b1, 4'b1010, 2, 1);
    finish("t4b", 1, 10, 9, 1);

    // Start re-pulsed mid-run is ignored
    push_copies(4'b1101, 2); exp_q.push_back(2);
    kick(1'b0, 4'b0000, 2, 0);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; pat_sel = 1'b1; pattern = 4'b0110; reps = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    finish("t5_restart", 5, 9, 8, 0);

    // Abort during the second copy after two of its bits
    push_copies(4'b1101, 1); exp_q.push_back(1); exp_q.push_back(1);
    kick(1'b0, 4'b0000, 4, 0);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_output_bit", int'(output_bit), 0);
    chk("abort_bit_valid", int'(bit_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (6) @(posedge clk);
    #1 chk("abort_queue_drained", exp_q.size(), 0);

    // Abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; reps = 8'd1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_done", int'(done), 0);
    repeat (3) @(posedge clk);

    // Async reset mid-SEND, then a clean rerun
    exp_q.push_back(1);
    kick(1'b0, 4'b0000, 1, 0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("async_rst_output_bit", int'(output_bit), 0);
    chk("async_rst_bit_valid", int'(bit_valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b1;
    chk("async_rst_queue", exp_q.size(), 0);
    push_copies(4'b1101, 1); exp_q.push_back(2);
    kick(1'b0, 4'b0000, 1, 0);
    finish("t6_rerun", 1, 5, 4, 0);

    // Maximum repeat count, counter must not wrap
    push_copies(4'b1101, 255); exp_q.push_back(2);
    kick(1'b0, 4'b0000, 255, 0);
    finish("t7_max_reps", 1, 1021, 1020, 0);

    repeat (2) @(posedge clk);
    #1 chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
